// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit adder/subtractor, CHUNK bits of carry chain per stage
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; overrides every other input
//   in_valid   operand set a/b/sub presented
//   in_ready   block can take an operand set this cycle (0 while rst is high)
//   a, b       operands, WIDTH bits
//   sub        0: a+b, 1: a-b (computed as a + ~b + 1)
//   out_valid  result presented on sum/carry/overflow/zero
//   out_ready  consumer takes the result this cycle
//   sum        result modulo 2^WIDTH
//   carry      carry out of the MSB (for subtraction: 1 = no borrow)
//   overflow   two's complement overflow
//   zero       sum is all zeros
//
// WIDTH must be a multiple of CHUNK. STAGES = WIDTH/CHUNK pipeline registers
// sit in front of the output register, so an op accepted at edge t is shown
// after edge t+STAGES when nothing stalls. The whole pipe moves together
// (adv) or holds together; bubbles are not squeezed out.

module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

    // Pipeline register k holds an op whose slices 0..k-1 are already summed
    // and which is waiting for slice k to be added. Register 0 is the capture
    // register: operands with b already inverted for subtraction and cin=sub.
    logic             p_valid [STAGES];
    logic [WIDTH-1:0] p_a     [STAGES];
    logic [WIDTH-1:0] p_b     [STAGES];
    logic [WIDTH-1:0] p_s     [STAGES];
    logic             p_c     [STAGES];

    logic [CHUNK:0]   slice_res [STAGES];
    logic [WIDTH-1:0] nxt_s     [STAGES];

    logic             adv;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_carry;
    logic             fin_ovf;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    // One CHUNK-bit add per register; its result is merged into the
    // partially built sum that travels with the op.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        assign slice_res[k] = {1'b0, p_a[k][k*CHUNK +: CHUNK]}
                            + {1'b0, p_b[k][k*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, p_c[k]};
        assign nxt_s[k] = (p_s[k] & ~(SLICE_MASK << (k*CHUNK)))
                        | (WIDTH'(slice_res[k][CHUNK-1:0]) << (k*CHUNK));
    end

    // The last slice is resolved straight into the output register.
    assign fin_sum   = nxt_s[LAST];
    assign fin_carry = slice_res[LAST][CHUNK];
    // p_b already holds the inverted operand for subtraction, so the plain
    // same-sign-in / different-sign-out rule covers both operations.
    assign fin_ovf   = (p_a[LAST][WIDTH-1] == p_b[LAST][WIDTH-1])
                    && (fin_sum[WIDTH-1] != p_a[LAST][WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                p_valid[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            p_valid[0] <= in_valid;
            // Operands are only sampled on an accepted edge; a bubble keeps
            // the stale contents, which are never presented as valid.
            if (in_valid) begin
                p_a[0] <= a;
                p_b[0] <= b ^ {WIDTH{sub}};
                p_s[0] <= '0;
                p_c[0] <= sub;
            end
            for (int k = 1; k < STAGES; k++) begin
                p_valid[k] <= p_valid[k-1];
                p_a[k]     <= p_a[k-1];
                p_b[k]     <= p_b[k-1];
                p_s[k]     <= nxt_s[k-1];
                p_c[k]     <= slice_res[k-1][CHUNK];
            end
            out_valid <= p_valid[LAST];
            sum       <= fin_sum;
            carry     <= fin_carry;
            overflow  <= fin_ovf;
            zero      <= (fin_sum == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - scoreboard bench for pipelined_addsub (WIDTH=32, CHUNK=8)

module tb_pipelined_addsub;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        logic             z;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_acc = 0;
    logic [WIDTH-1:0] last_sum = '0;
    logic [2:0]       last_flags = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        exp_t   e;
        longint ux, uy, ur, sx, sy, r, smax, smin;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) << (WIDTH-1)) - 1;
        smin = -(longint'(1) << (WIDTH-1));
        if (s) begin
            ur  = ux - uy;
            r   = sx - sy;
            e.c = (ux >= uy);
        end else begin
            ur  = ux + uy;
            r   = sx + sy;
            e.c = (ur >= (longint'(1) << WIDTH));
        end
        e.s = ur[WIDTH-1:0];
        e.o = (r > smax) || (r < smin);
        e.z = (e.s == '0);
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            4:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: every cycle, away from the edge.
    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_sum = '0;
    logic [2:0]       prev_flags = '0;
    always @(negedge clk) begin
        exp_t e;
        #2;
        chk("in_ready", 64'(in_ready), 64'((!out_valid || out_ready) && !rst));
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_sum", 64'(sum), 64'(prev_sum));
                chk("hold_flags", 64'({carry, overflow, zero}), 64'(prev_flags));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", 64'(sum), 64'(e.s));
                    chk("flags_cvz", 64'({carry, overflow, zero}), 64'({e.c, e.o, e.z}));
                    pop_cyc.push_back(cyc);
                    last_sum   = sum;
                    last_flags = {carry, overflow, zero};
                end
            end
            prev_hold  = out_valid && !out_ready;
            prev_sum   = sum;
            prev_flags = {carry, overflow, zero};
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        int guard = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back(model(x, y, s));
            last_acc = cyc + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom();
        b        = $urandom();
        sub      = 1'($urandom());
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            #3;
            guard++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic directed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                            input logic [WIDTH-1:0] es, input logic ec, input logic eo, input logic ez,
                            input bit check_lat);
        pop_cyc.delete();
        send(x, y, s);
        drain();
        chk("dir_sum", 64'(last_sum), 64'(es));
        chk("dir_flags_cvz", 64'(last_flags), 64'({ec, eo, ez}));
        if (check_lat) begin
            if (pop_cyc.size() == 0) chk("latency_seen", 64'd0, 64'd1);
            else chk("latency", 64'(pop_cyc[0] - last_acc), 64'(STAGES));
        end
    endtask

    initial begin
        bit done;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", 64'({sum, carry, overflow, zero}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases.
        directed(32'hffff_ffff, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        directed(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hffff_fffe, 1'b0, 1'b0, 1'b0, 1'b1);
        directed(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        directed(32'h7fff_ffff, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        directed(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7fff_ffff, 1'b1, 1'b1, 1'b0, 1'b0);

        // 16 back-to-back random ops, results on consecutive cycles.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) send(rnd(), rnd(), 1'($urandom()));
        drain();
        chk("b2b_count", 64'(pop_cyc.size()), 64'd16);
        if (pop_cyc.size() == 16) chk("b2b_span", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);

        // 8 ops streaming with a 3-cycle consumer stall in the middle.
        pop_cyc.delete();
        fork
            for (int i = 0; i < 8; i++) send(rnd(), rnd(), 1'($urandom()));
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(pop_cyc.size()), 64'd8);

        // Reset with 3 ops in flight: nothing may come out afterwards.
        for (int i = 0; i < 3; i++) send(rnd(), rnd(), 1'($urandom()));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outputs", 64'({sum, carry, overflow, zero}), 64'd0);
        pop_cyc.delete();
        repeat (STAGES + 3) @(negedge clk);
        #3;
        chk("rst_no_stale", 64'(pop_cyc.size()), 64'd0);

        // Random traffic with random consumer back-pressure and input gaps.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(rnd(), rnd(), 1'($urandom()));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
